// File: rtl/rom_serial_link.sv
// ROM-sweep serial link with a loopback receiver: on an ena rising edge, sweep N ROM words,
// frame each addr/data pair onto ser_clk/ser_dat/ser_frm and republish it on rx_addr/rx_data.
// Latency: first frame starts 1 cycle after the start edge; strobe 1 cycle after last bit sampled.
// Backpressure: none; free-running burst, ena edges while busy are dropped (not queued).
// Ports: clk/rst_n (sync active-low)/ena in; tx_addr/tx_data word being sent; ser_clk/ser_dat/
// ser_frm framed link; rx_strb/rx_addr/rx_data received word; busy/done burst status.
// Optional: define PARITY_EN to append an even-parity bit and add the par_err output.
module rom_serial_link #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 4,
   parameter int START_ADDR = 0,
   parameter int COUNT      = 0,
   parameter int CLK_DIV    = 1,
   parameter int GAP        = 2,
   parameter int ROM_MULT   = 3,
   parameter int ROM_OFFS   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   output logic [ADDR_W-1:0] tx_addr,
   output logic [DATA_W-1:0] tx_data,
   output logic              ser_clk,
   output logic              ser_dat,
   output logic              ser_frm,
   output logic              rx_strb,
   output logic [ADDR_W-1:0] rx_addr,
   output logic [DATA_W-1:0] rx_data,
   output logic              busy,
   output logic              done
`ifdef PARITY_EN
   ,
   output logic              par_err
`endif
);

   localparam int DEPTH   = 1 << ADDR_W;
   localparam int N_WORDS = (COUNT == 0) ? DEPTH : COUNT;
   localparam int PAY_W   = ADDR_W + DATA_W;
`ifdef PARITY_EN
   localparam int FB      = PAY_W + 1;
`else
   localparam int FB      = PAY_W;
`endif
   localparam int BIT_CYC = 2 * CLK_DIV;
   localparam int PH_W    = $clog2(BIT_CYC);
   localparam int BC_W    = $clog2(FB);
   localparam int GC_W    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int WC_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   localparam logic [PH_W-1:0] PH_HI     = PH_W'(CLK_DIV);
   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BIT_CYC - 1);
   localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(FB - 1);
   localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP - 1);
   localparam logic [WC_W-1:0] WORD_LAST = WC_W'(N_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

   // ROM contents are a closed-form function of the address, truncated to DATA_W bits.
   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      logic [31:0] v;
      v = {{(32-ADDR_W){1'b0}}, a} * ROM_MULT[31:0] + ROM_OFFS[31:0];
      return v[DATA_W-1:0];
   endfunction

   function automatic logic [FB-1:0] frame_of(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      d = rom_word(a);
`ifdef PARITY_EN
      return {a, d, ^{a, d}};
`else
      return {a, d};
`endif
   endfunction

   state_t            state, state_nxt;
   logic              ena_q;
   logic [PH_W-1:0]   ph_cnt;
   logic [BC_W-1:0]   bit_cnt;
   logic [GC_W-1:0]   gap_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [FB-1:0]     sreg;
   logic              start, bit_end, frame_end, gap_end, last_word;
   logic [ADDR_W-1:0] nxt_addr;
   logic [ADDR_W-1:0] first_addr;

   // Internal copy of the serial data line; the receiver listens here rather than to the port.
   logic              ser_dat_line;

   assign first_addr = START_ADDR[ADDR_W-1:0];
   assign start      = (state == S_IDLE) && ena && !ena_q;
   assign bit_end    = (ph_cnt == PH_LAST);
   assign frame_end  = (state == S_SHIFT) && bit_end && (bit_cnt == BIT_LAST);
   assign gap_end    = (state == S_GAP) && (gap_cnt == GAP_LAST);
   assign last_word  = (word_cnt == WORD_LAST);
   // Wraps modulo DEPTH by construction of the ADDR_W-bit sum.
   assign nxt_addr   = tx_addr + ADDR_W'(1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         S_SHIFT: if (frame_end) state_nxt = S_GAP;
         S_GAP:   if (gap_end) state_nxt = last_word ? S_DONE : S_SHIFT;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy    = (state == S_SHIFT) || (state == S_GAP);
      done    = (state == S_DONE);
      ser_frm = (state == S_SHIFT);
      ser_clk = ser_frm && (ph_cnt >= PH_HI);
   end

   assign ser_dat_line = ser_frm & sreg[FB-1];
   assign ser_dat      = ser_dat_line;

   // ---------------- transmit datapath ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // Edge detector starts "high" so an ena held through reset release is not an edge.
         ena_q    <= 1'b1;
         ph_cnt   <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         word_cnt <= '0;
         sreg     <= '0;
         tx_addr  <= '0;
         tx_data  <= '0;
      end else begin
         ena_q <= ena;
         if (start) begin
            tx_addr  <= first_addr;
            tx_data  <= rom_word(first_addr);
            sreg     <= frame_of(first_addr);
            ph_cnt   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
         end else if (state == S_SHIFT) begin
            gap_cnt <= '0;
            if (bit_end) begin
               ph_cnt  <= '0;
               sreg    <= {sreg[FB-2:0], 1'b0};
               bit_cnt <= frame_end ? '0 : bit_cnt + BC_W'(1);
            end else begin
               ph_cnt <= ph_cnt + PH_W'(1);
            end
         end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt + GC_W'(1);
            if (gap_end && !last_word) begin
               tx_addr  <= nxt_addr;
               tx_data  <= rom_word(nxt_addr);
               sreg     <= frame_of(nxt_addr);
               ph_cnt   <= '0;
               bit_cnt  <= '0;
               word_cnt <= word_cnt + WC_W'(1);
            end
         end
      end
   end

   // ---------------- loopback receiver ----------------
   logic              clk_q;
   logic [FB-2:0]     rx_sreg;
   logic [BC_W-1:0]   rx_cnt;
   logic [FB-1:0]     rx_word;

   // Word as it will look once the bit currently on the line is shifted in.
   assign rx_word = {rx_sreg, ser_dat_line};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_q   <= 1'b0;
         rx_sreg <= '0;
         rx_cnt  <= '0;
         rx_strb <= 1'b0;
         rx_addr <= '0;
         rx_data <= '0;
`ifdef PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         clk_q   <= ser_clk;
         rx_strb <= 1'b0;
`ifdef PARITY_EN
         par_err <= 1'b0;
`endif
         if (!ser_frm) begin
            rx_cnt <= '0;
         end else if (ser_clk && !clk_q) begin
            rx_sreg <= rx_word[FB-2:0];
            if (rx_cnt == BIT_LAST) begin
               rx_cnt <= '0;
`ifdef PARITY_EN
               // Even parity over the whole frame must come out zero.
               if (^rx_word) begin
                  par_err <= 1'b1;
               end else begin
                  rx_addr <= rx_word[FB-1 -: ADDR_W];
                  rx_data <= rx_word[FB-1-ADDR_W -: DATA_W];
                  rx_strb <= 1'b1;
               end
`else
               rx_addr <= rx_word[FB-1 -: ADDR_W];
               rx_data <= rx_word[FB-1-ADDR_W -: DATA_W];
               rx_strb <= 1'b1;
`endif
            end else begin
               rx_cnt <= rx_cnt + BC_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_rom_serial_link.sv
module tb_rom_serial_link;

`ifdef PARITY_EN
   localparam int FB = 9;
`else
   localparam int FB = 8;
`endif
   // u0/u1: CLK_DIV=1, GAP=2.  u2: CLK_DIV=3.
   localparam int P0   = 2 * FB + 2;
   localparam int OFF0 = (FB - 1) * 2 + 1 + 1;
   localparam int P2   = 6 * FB + 2;
   localparam int OFF2 = (FB - 1) * 6 + 3 + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       busy0, done0, frm0, sclk0, sdat0, strb0;
   logic [3:0] txa0, txd0, rxa0, rxd0;
   logic       busy1, done1, frm1, sclk1, sdat1, strb1;
   logic [3:0] txa1, txd1, rxa1, rxd1;
   logic       busy2, done2, frm2, sclk2, sdat2, strb2;
   logic [3:0] txa2, txd2, rxa2, rxd2;
`ifdef PARITY_EN
   logic       pe0, pe1, pe2;
`endif

   rom_serial_link u0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tx_addr(txa0), .tx_data(txd0),
      .ser_clk(sclk0), .ser_dat(sdat0), .ser_frm(frm0), .rx_strb(strb0),
      .rx_addr(rxa0), .rx_data(rxd0), .busy(busy0), .done(done0)
`ifdef PARITY_EN
      , .par_err(pe0)
`endif
   );

   rom_serial_link #(.START_ADDR(14), .COUNT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tx_addr(txa1), .tx_data(txd1),
      .ser_clk(sclk1), .ser_dat(sdat1), .ser_frm(frm1), .rx_strb(strb1),
      .rx_addr(rxa1), .rx_data(rxd1), .busy(busy1), .done(done1)
`ifdef PARITY_EN
      , .par_err(pe1)
`endif
   );

   rom_serial_link #(.CLK_DIV(3), .COUNT(3)) u2 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tx_addr(txa2), .tx_data(txd2),
      .ser_clk(sclk2), .ser_dat(sdat2), .ser_frm(frm2), .rx_strb(strb2),
      .rx_addr(rxa2), .rx_data(rxd2), .busy(busy2), .done(done2)
`ifdef PARITY_EN
      , .par_err(pe2)
`endif
   );

   wire [21:0] all0 = {busy0, done0, frm0, sclk0, sdat0, strb0, txa0, txd0, rxa0, rxd0};
   wire [21:0] all1 = {busy1, done1, frm1, sclk1, sdat1, strb1, txa1, txd1, rxa1, rxd1};
   wire [21:0] all2 = {busy2, done2, frm2, sclk2, sdat2, strb2, txa2, txd2, rxa2, rxd2};

   typedef struct {
      int cyc;
      int addr;
      int data;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t pq[$];
   int   d0[$];
   int   d1[$];
   int   d2[$];

   // Hand-computed (a*3+5) mod 16 for a = 0..15.
   int rom_tab[16] = '{5, 8, 11, 14, 1, 4, 7, 10, 13, 0, 3, 6, 9, 12, 15, 2};

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic unexpected(input string nm, input int a, input int d);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d (addr %0d data %0d), none expected", nm, cyc, a, d);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Push the expected strobes/done for all three instances of a burst started at cycle e.
   // par_word selects a u0 word whose strobe is replaced by a parity error (-1: none).
   task automatic push_burst(input int e, input int par_word);
      exp_t x;
      for (int n = 0; n < 16; n++) begin
         x.cyc = e + 1 + n * P0 + OFF0;
         if (n == par_word) begin
            x.addr = n - 1;
            x.data = rom_tab[n - 1];
            pq.push_back(x);
         end else begin
            x.addr = n;
            x.data = rom_tab[n];
            q0.push_back(x);
         end
      end
      d0.push_back(e + 1 + 16 * P0);
      for (int n = 0; n < 4; n++) begin
         x.cyc  = e + 1 + n * P0 + OFF0;
         x.addr = (14 + n) % 16;
         x.data = rom_tab[(14 + n) % 16];
         q1.push_back(x);
      end
      d1.push_back(e + 1 + 4 * P0);
      for (int n = 0; n < 3; n++) begin
         x.cyc  = e + 1 + n * P2 + OFF2;
         x.addr = n;
         x.data = rom_tab[n];
         q2.push_back(x);
      end
      d2.push_back(e + 1 + 3 * P2);
   endtask

   // Scoreboard monitor: pops an expectation whenever a DUT presents a strobe or done.
   always @(negedge clk) begin : mon
      exp_t e;
      if (strb0) begin
         if (q0.size() == 0) unexpected("u0_strobe", rxa0, rxd0);
         else begin
            e = q0.pop_front();
            chk("u0_strb_cycle", cyc, e.cyc);
            chk("u0_rx_addr", rxa0, e.addr);
            chk("u0_rx_data", rxd0, e.data);
         end
      end
      if (strb1) begin
         if (q1.size() == 0) unexpected("u1_strobe", rxa1, rxd1);
         else begin
            e = q1.pop_front();
            chk("u1_strb_cycle", cyc, e.cyc);
            chk("u1_rx_addr", rxa1, e.addr);
            chk("u1_rx_data", rxd1, e.data);
         end
      end
      if (strb2) begin
         if (q2.size() == 0) unexpected("u2_strobe", rxa2, rxd2);
         else begin
            e = q2.pop_front();
            chk("u2_strb_cycle", cyc, e.cyc);
            chk("u2_rx_addr", rxa2, e.addr);
            chk("u2_rx_data", rxd2, e.data);
         end
      end
      if (done0) begin
         if (d0.size() == 0) unexpected("u0_done", txa0, txd0);
         else begin
            chk("u0_done_cycle", cyc, d0.pop_front());
            chk("u0_busy_in_done", busy0, 0);
         end
      end
      if (done1) begin
         if (d1.size() == 0) unexpected("u1_done", txa1, txd1);
         else begin
            chk("u1_done_cycle", cyc, d1.pop_front());
            chk("u1_busy_in_done", busy1, 0);
         end
      end
      if (done2) begin
         if (d2.size() == 0) unexpected("u2_done", txa2, txd2);
         else begin
            chk("u2_done_cycle", cyc, d2.pop_front());
            chk("u2_busy_in_done", busy2, 0);
         end
      end
`ifdef PARITY_EN
      if (pe0) begin
         if (pq.size() == 0) unexpected("u0_par_err", rxa0, rxd0);
         else begin
            e = pq.pop_front();
            chk("u0_par_err_cycle", cyc, e.cyc);
            chk("u0_rx_addr_held", rxa0, e.addr);
            chk("u0_rx_data_held", rxd0, e.data);
         end
      end
      if (pe1) unexpected("u1_par_err", rxa1, rxd1);
      if (pe2) unexpected("u2_par_err", rxa2, rxd2);
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int e1, e2, e3;
      logic [7:0] fr;
      fr = '0;

      // ---- reset state ----
      rst_n = 1'b0;
      ena   = 1'b0;
      wait_until(3);
      chk("u0_reset_outputs", all0, 0);
      chk("u1_reset_outputs", all1, 0);
      chk("u2_reset_outputs", all2, 0);
      rst_n = 1'b1;
      wait_until(4);

      // ---- scenario 1/2/4/5: one burst on all instances ----
      ena = 1'b1;
      e1  = cyc;
      push_burst(e1, -1);
      for (int c = e1 + 1; c <= e1 + 2 * FB + 1; c++) begin
         wait_until(c);
         if (c == e1 + 1) begin
            chk("u0_busy_first", busy0, 1);
            chk("u0_frm_first", frm0, 1);
            chk("u0_tx_addr_first", txa0, 0);
            chk("u0_tx_data_first", txd0, 5);
            chk("u1_tx_addr_first", txa1, 14);
            chk("u1_tx_data_first", txd1, 15);
         end
         if (c == e1 + 3) ena = 1'b0;
         if (c < e1 + 17 && ((c - e1 - 1) % 2) == 0) fr[7 - (c - e1 - 1) / 2] = sdat0;
         if (c == e1 + 3) chk("u2_sclk_low_phase", sclk2, 0);
         if (c == e1 + 4) chk("u2_sclk_high_start", sclk2, 1);
         if (c == e1 + 6) chk("u2_sclk_high_end", sclk2, 1);
         if (c == e1 + 7) chk("u2_sclk_next_low", sclk2, 0);
         if (c == e1 + 2 * FB) chk("u0_frm_last_cycle", frm0, 1);
         if (c == e1 + 2 * FB + 1) chk("u0_gap_lines", {frm0, sclk0, sdat0}, 0);
      end
      chk("u0_frame0_bits", fr, 8'b0000_0101);

      wait_until(e1 + 1 + P0);
      chk("u0_tx_addr_word1", txa0, 1);
      chk("u0_tx_data_word1", txd0, 8);
      chk("u0_frm_word1", frm0, 1);

      // ena re-triggered while busy must be ignored.
      wait_until(e1 + 40);
      ena = 1'b1;
      wait_until(e1 + 6 * FB);
      chk("u2_frm_last_cycle", frm2, 1);
      wait_until(e1 + 6 * FB + 1);
      chk("u2_frm_gap", frm2, 0);
      wait_until(e1 + 70);
      ena = 1'b0;

      wait_until(e1 + 1 + 16 * P0 + 4);
      chk("u0_busy_after", busy0, 0);
      chk("u0_tx_addr_hold", txa0, 15);
      chk("u0_tx_data_hold", txd0, 2);
      chk("u0_rx_addr_hold", rxa0, 15);
      chk("u0_rx_data_hold", rxd0, 2);
      chk("u1_rx_addr_last", rxa1, 1);
      chk("u1_rx_data_last", rxd1, 8);
      chk("u2_rx_addr_last", rxa2, 2);
      chk("u2_rx_data_last", rxd2, 11);
      chk("u0_strobes_left", q0.size(), 0);
      chk("u1_strobes_left", q1.size(), 0);
      chk("u2_strobes_left", q2.size(), 0);
      chk("u0_done_left", d0.size(), 0);

      // ---- scenario 3: reset mid-frame, ena held high through reset release ----
      wait_until(cyc + 2);
      ena = 1'b1;
      e2  = cyc;
      wait_until(e2 + 10);
      rst_n = 1'b0;
      wait_until(e2 + 11);
      rst_n = 1'b1;
      chk("u0_midreset_outputs", all0, 0);
      chk("u1_midreset_outputs", all1, 0);
      chk("u2_midreset_outputs", all2, 0);
      wait_until(e2 + 20);
      chk("u0_no_start_held_ena", busy0, 0);
      chk("u2_no_start_held_ena", busy2, 0);
      ena = 1'b0;
      wait_until(e2 + 30);
      ena = 1'b1;
      e3  = cyc;
      push_burst(e3, -1);
      wait_until(e3 + 1);
      chk("u0_restart_addr", txa0, 0);
      chk("u0_restart_busy", busy0, 1);
      wait_until(e3 + 2);
      ena = 1'b0;
      wait_until(e3 + 1 + 16 * P0 + 4);
      chk("u0_strobes_left_r", q0.size(), 0);
      chk("u1_strobes_left_r", q1.size(), 0);
      chk("u2_strobes_left_r", q2.size(), 0);
      chk("u0_done_left_r", d0.size(), 0);

`ifdef PARITY_EN
      // ---- scenario 6: corrupt the parity bit of word 2 (addr 2, data 11, parity 0) ----
      begin
         int e4;
         wait_until(cyc + 2);
         ena = 1'b1;
         e4  = cyc;
         push_burst(e4, 2);
         wait_until(e4 + 2);
         ena = 1'b0;
         wait_until(e4 + 1 + 2 * P0 + (FB - 1) * 2);
         force u0.ser_dat_line = 1'b1;
         wait_until(e4 + 1 + 2 * P0 + (FB - 1) * 2 + 2);
         release u0.ser_dat_line;
         wait_until(e4 + 1 + 16 * P0 + 4);
         chk("u0_strobes_left_p", q0.size(), 0);
         chk("u0_par_err_left", pq.size(), 0);
         chk("u0_done_left_p", d0.size(), 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_serial_link.md
Name: rom_serial_link

Overview:
Parametrised ROM-sweep serial link with internal loopback receiver. A rising edge on ena starts a burst. The block reads COUNT consecutive ROM words, presents each address/data pair on tx_addr/tx_data, serialises each pair onto a framed ser_clk/ser_dat/ser_frm link, then deserialises it and republishes it on rx_addr/rx_data with a strobe. It is the generalised successor of the fixed 4-bit ROM-to-serial competition block: width, depth, burst, bit rate and ROM contents are all configurable.

Parameters:
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
DATA_W, 4, ROM word width
START_ADDR, 0, first address of a burst
COUNT, 0, words per burst; 0 means a full DEPTH-word sweep
CLK_DIV, 1, clk cycles per serial clock half-period (>=1)
GAP, 2, idle clk cycles with ser_frm low between frames (>=1)
ROM_MULT, 3, ROM content: data[a] = (a*ROM_MULT + ROM_OFFS) mod 2**DATA_W
ROM_OFFS, 5, see ROM_MULT

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  synchronous active-low reset
ena  in  1  burst start, rising-edge triggered, any pulse length
tx_addr  out  ADDR_W  address of the word currently being sent
tx_data  out  DATA_W  ROM data at tx_addr
ser_clk  out  1  serial bit clock
ser_dat  out  1  serial data, MSB first, address bits then data bits
ser_frm  out  1  high for the duration of each frame
rx_strb  out  1  one-cycle pulse when rx_addr/rx_data update
rx_addr  out  ADDR_W  last received address, held between strobes
rx_data  out  DATA_W  last received data, held between strobes
busy  out  1  high from burst start until done
done  out  1  one-cycle pulse at end of burst

Behaviour:
- Reset (rst_n low at a clk edge): all outputs go to 0 at that edge. The ena edge-detect register is set to 1, so an ena held high through reset release does not start a burst. The receiver shift register and bit counter clear. A frame in progress is abandoned and produces no strobe.
- Start edge: cycle E is the cycle in which ena is sampled 1 and its previous sample was 0, with the FSM in IDLE. At edge E+1: busy=1, ser_frm=1, tx_addr=START_ADDR, tx_data=ROM[START_ADDR].
- ena rising edges while busy are ignored and not queued.
- FSM states: IDLE -> SHIFT (on start edge) -> GAP (after the last frame bit) -> SHIFT (more words remain) or DONE (burst complete) -> IDLE.
- DONE lasts one cycle: done=1 and busy=0 in that cycle.
- Frame: FB = ADDR_W+DATA_W bits, MSB first. Each bit lasts 2*CLK_DIV cycles.
  - ser_clk is low for the first CLK_DIV cycles of a bit and high for the last CLK_DIV cycles.
  - ser_dat changes only at bit start.
  - ser_frm is high for exactly FB*2*CLK_DIV cycles, then low for GAP cycles.
  - ser_clk and ser_dat are 0 whenever ser_frm is 0.
- Word period: P = FB*2*CLK_DIV + GAP cycles.
  - Word n's frame starts at E+1+n*P.
  - tx_addr/tx_data update at each frame start and hold through GAP.
  - done pulses at E+1+N*P, where N = COUNT (or DEPTH when COUNT=0).
- Address arithmetic: address increments modulo DEPTH, so START_ADDR+N > DEPTH wraps to 0. ROM data is computed with DATA_W-bit truncation.
- Receiver:
  - Samples ser_dat in the first cycle in which ser_clk is high for each bit and shifts it into an FB-bit register.
  - After bit FB-1 is sampled, rx_addr/rx_data load and rx_strb pulses in the next cycle. With CLK_DIV=1 that is cycle E+1+n*P+2*FB.
  - The bit counter resets whenever ser_frm is low.
- After done, tx_addr/tx_data/rx_addr/rx_data hold their last values until the next burst or reset.

Optional Feature:
PARITY_EN:
- Defined:
  - One even-parity bit is appended after the data LSB, so FB = ADDR_W+DATA_W+1.
  - The receiver checks parity. On mismatch it suppresses rx_strb, leaves rx_addr/rx_data unchanged and pulses an extra output par_err (1 bit, reset 0) for one cycle in place of the strobe.
  - In loopback no mismatch occurs. The bench forces one by overriding ser_dat inside the block.
- Undefined: no parity bit, no par_err port, and FB = ADDR_W+DATA_W.

Test Plan:
1. Defaults (FB=8, P=18, N=16): rst_n low for 3 cycles; 1 cycle after release, ena high for 3 cycles -> first frame ser_dat = 0000_0101, first rx_strb at E+17 with rx_addr=0, rx_data=5. Second word: addr 1, data 8. Third word: addr 2, data 0xB. done at E+289.
2. ena pulsed again at E+40 while busy, and held high for 30 cycles -> ignored; exactly 16 strobes, single done.
3. Reset mid-frame: rst_n low at E+10 for one cycle -> all outputs 0 at E+11, no rx_strb, busy=0. A new ena edge starts cleanly from START_ADDR.
4. START_ADDR=14, COUNT=4 -> rx_addr sequence 14, 15, 0, 1, with rx_data 47 mod 16 = 15, 50 mod 16 = 2, 5, 8.
5. CLK_DIV=3 -> each ser_clk phase lasts 3 cycles, ser_frm high 48 cycles, P=50, and rx values match scenario 1.
6. PARITY_EN defined, ser_dat forced inverted on the parity bit of word 2 -> par_err pulse instead of rx_strb; rx_addr stays 1; all other words strobe normally.
